// File: rtl/seg_display_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_pkg
// Shared constants and helpers for the seven-segment display slice.
//
// Segment bytes are active-low, ordered {a,b,c,d,e,f,g,dp}, so a 0 bit lights
// a segment and 8'hFF is a fully dark digit. Every font entry leaves the dp
// bit (bit 0) at 1; the decimal point is merged in separately by the driver.
// -----------------------------------------------------------------------------
package seg_display_pkg;

  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;
  localparam logic [7:0] SEG_A = 8'h11;
  localparam logic [7:0] SEG_B = 8'hC1;
  localparam logic [7:0] SEG_C = 8'h63;
  localparam logic [7:0] SEG_D = 8'h85;
  localparam logic [7:0] SEG_E = 8'h61;
  localparam logic [7:0] SEG_F = 8'h71;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 0;

  // Hex font lookup; the returned byte always has its dp segment off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
// Combinational 4-bit hex digit to active-low 7-segment font byte.
//
// Ports:
//   nibble  in   4  hex value 0..F
//   seg     out  8  {a,b,c,d,e,f,g,dp}, active-low, dp always off
// -----------------------------------------------------------------------------
module seg_hex_decoder (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  import seg_display_pkg::*;

  // Pure table lookup so the font lives in one place (the package).
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
// Time-multiplexed hex driver for NUM_DIGITS common-select 7-segment digits.
// One digit is driven per slot of SCAN_DIV clocks; the first BLANK_CYC clocks
// of each slot are dark to stop the previous digit ghosting into the next.
// The displayed value is captured once per frame so a frame never mixes
// old and new digits.
//
// Optional feature macro: SEG_BLINK_EN (per-digit blinking, half-period of
// BLINK_FRAMES frames). Without it IN_blink is ignored.
//
// Ports:
//   IN_clk       in   1             clock, all state on posedge
//   IN_rst_n     in   1             synchronous active-low reset
//   IN_value     in   4*NUM_DIGITS  hex nibbles, [3:0] = digit 0 (rightmost)
//   IN_dp        in   NUM_DIGITS    decimal point per digit, 1 = lit
//   IN_blank_lz  in   1             1 = blank leading zero digits
//   IN_enable    in   1             0 = display dark, counters keep running
//   IN_blink     in   NUM_DIGITS    per-digit blink request
//   OUT_choice   out  NUM_DIGITS    one-hot digit select, active-high
//   OUT_seg      out  8             segments, active-low {a..g,dp}
//   OUT_frame    out  1             pulse on first output cycle of a frame
// -----------------------------------------------------------------------------
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      IN_clk,
  input  logic                      IN_rst_n,
  input  logic [4*NUM_DIGITS-1:0]   IN_value,
  input  logic [NUM_DIGITS-1:0]     IN_dp,
  input  logic                      IN_blank_lz,
  input  logic                      IN_enable,
  input  logic [NUM_DIGITS-1:0]     IN_blink,
  output logic [NUM_DIGITS-1:0]     OUT_choice,
  output logic [7:0]                OUT_seg,
  output logic                      OUT_frame
);

  import seg_display_pkg::*;

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYC);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap_value;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_nibble;
  logic [7:0]              font_seg;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [7:0]              digit_seg;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_end  = slot_end && (idx == IDX_LAST);
  assign cur_nibble = snap_value[{idx, 2'b00} +: 4];

  // Prescaler and digit index. The snapshot only moves at the frame boundary,
  // which is what keeps every digit of a frame showing the same value.
  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (frame_end) begin
        snap_value <= IN_value;
        snap_dp    <= IN_dp;
      end
    end
  end

  seg_hex_decoder u_hex_decoder (
    .nibble (cur_nibble),
    .seg    (font_seg)
  );

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 of the snapshot are all
  // zero; scanning from the top digit down lets one running AND do it.
  always_comb begin : lz_scan
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run && (snap_value[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0]       frame_cnt;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] snap_blink;

  // Frame counter flips the blink phase every BLINK_FRAMES frames; the blink
  // mask is captured alongside the value so it is frame-coherent too.
  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_blink  <= '0;
    end else if (frame_end) begin
      snap_blink <= IN_blink;
      if (frame_cnt == FC_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{IN_blink, 1'(BLINK_FRAMES)};
`endif

  // Segment byte for the digit currently in its slot. Leading-zero blanking
  // only darkens a..g, so a dp on a blanked digit still shows; a blinking
  // digit in its hidden phase goes fully dark, dp included.
  always_comb begin
    digit_seg = font_seg;
    if (IN_blank_lz && (idx != '0) && zero_from[idx]) begin
      digit_seg = SEG_BLANK;
    end
    if (snap_dp[idx]) begin
      digit_seg[SEG_DP_BIT] = 1'b0;
    end
`ifdef SEG_BLINK_EN
    if (blink_phase && snap_blink[idx]) begin
      digit_seg = SEG_BLANK;
    end
`endif
  end

  // Output register: one cycle behind the slot state. The anti-ghost gap and
  // the enable both force the select off and the segments dark.
  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      OUT_choice <= '0;
      OUT_seg    <= SEG_BLANK;
      OUT_frame  <= 1'b0;
    end else begin
      if (({1'b0, cnt} < BLANK_LIM) || !IN_enable) begin
        OUT_choice <= '0;
        OUT_seg    <= SEG_BLANK;
      end else begin
        OUT_choice <= NUM_DIGITS'(1) << idx;
        OUT_seg    <= digit_seg;
      end
      OUT_frame <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
// Directed self-checking bench for seg_scan_display with NUM_DIGITS=4,
// SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2. A frame is 16 output cycles:
// cycle c belongs to digit c/4, and c%4==0 is the dark gap cycle.
// Expected segment bytes per frame are packed {d3,d2,d1,d0}.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

  localparam int NUM_DIGITS   = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_FRAMES = 2;

`ifdef SEG_BLINK_EN
  localparam logic [31:0] BLINK_HIDDEN = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] BLINK_HIDDEN = 32'hFFFF_FF9F;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        enable;
  logic [3:0]  blink;
  logic [3:0]  choice;
  logic [7:0]  seg;
  logic        frame;

  int tests_run    = 0;
  int tests_failed = 0;

  seg_scan_display #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .IN_clk      (clk),
    .IN_rst_n    (rst_n),
    .IN_value    (value),
    .IN_dp       (dp),
    .IN_blank_lz (blank_lz),
    .IN_enable   (enable),
    .IN_blink    (blink),
    .OUT_choice  (choice),
    .OUT_seg     (seg),
    .OUT_frame   (frame)
  );

  // 10-unit clock; outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives all data inputs at once.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                               input logic lz, input logic en,
                               input logic [3:0] b);
    value    = v;
    dp       = d;
    blank_lz = lz;
    enable   = en;
    blink    = b;
  endtask

  // Advance to the next falling edge at which the frame pulse is high.
  task automatic waitFrame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Check the outputs for output cycle c of a frame.
  task automatic checkCycle(input string tag, input int c,
                            input logic [31:0] segs, input logic en);
    int         d;
    int         k;
    logic [3:0] exp_choice;
    logic [7:0] exp_seg;
    d = c / 4;
    k = c % 4;
    if (k == 0 || !en) begin
      exp_choice = 4'b0000;
      exp_seg    = 8'hFF;
    end else begin
      exp_choice = 4'b0001 << d;
      exp_seg    = segs[8*d +: 8];
    end
    checkOutput($sformatf("%s_c%0d_choice", tag, c), 32'(choice), 32'(exp_choice));
    checkOutput($sformatf("%s_c%0d_seg", tag, c), 32'(seg), 32'(exp_seg));
    checkOutput($sformatf("%s_c%0d_frame", tag, c), 32'(frame), 32'(c == 0));
  endtask

  // Check a whole frame starting from the falling edge carrying its pulse.
  task automatic checkFrameBody(input string tag, input logic [31:0] segs);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      checkCycle(tag, c, segs, 1'b1);
    end
  endtask

  // Optionally let one frame pass so new inputs are surely in the snapshot.
  task automatic checkFrame(input string tag, input logic [31:0] segs,
                            input bit skip);
    if (skip) waitFrame(tag);
    waitFrame(tag);
    checkFrameBody(tag, segs);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_choice"}, 32'(choice), 32'h0);
    checkOutput({tag, "_seg"}, 32'(seg), 32'hFF);
    checkOutput({tag, "_frame"}, 32'(frame), 32'h0);
  endtask

  initial begin
    // Reset held for three edges, then the first frame shows snapshot 0.
    rst_n = 1'b0;
    applyStimulus(16'h0000, 4'b0000, 1'b1, 1'b1, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    checkFrame("first", 32'hFFFF_FF03, 1'b0);

    // Plain scan of 1234 without blanking.
    applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b1, 4'b0000);
    checkFrame("hex1234", 32'h9F25_0D99, 1'b1);

    // Leading-zero blanking and decimal points.
    applyStimulus(16'h0050, 4'b0000, 1'b1, 1'b1, 4'b0000);
    checkFrame("lz_on", 32'hFFFF_4903, 1'b1);
    applyStimulus(16'h0050, 4'b0000, 1'b0, 1'b1, 4'b0000);
    checkFrame("lz_off", 32'h0303_4903, 1'b1);
    applyStimulus(16'h0000, 4'b0010, 1'b1, 1'b1, 4'b0000);
    checkFrame("dp_blank", 32'hFFFF_FE03, 1'b1);

    // Mid-frame value change only shows in the following frame.
    applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b1, 4'b0000);
    checkFrame("coh_pre", 32'h9F25_0D99, 1'b1);
    waitFrame("coh_old");
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 8) applyStimulus(16'hABCD, 4'b0000, 1'b0, 1'b1, 4'b0000);
      checkCycle("coh_old", c, 32'h9F25_0D99, 1'b1);
    end
    waitFrame("coh_new");
    checkFrameBody("coh_new", 32'h11C1_6385);

    // Enable dropped mid-slot, restored later; then reset mid-frame.
    applyStimulus(16'h1234, 4'b0000, 1'b1, 1'b1, 4'b0000);
    checkFrame("en_pre", 32'h9F25_0D99, 1'b1);
    waitFrame("en");
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      checkCycle("en", c, 32'h9F25_0D99, !(c == 6 || c == 7));
      if (c == 5) enable = 1'b0;
      if (c == 7) enable = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkReset("midrst");
    rst_n = 1'b1;
    checkFrame("post_rst", 32'hFFFF_FF03, 1'b0);

    // Blink: phase flips after two frames counted from reset.
    rst_n = 1'b0;
    applyStimulus(16'h0001, 4'b0000, 1'b1, 1'b1, 4'b0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkFrame("blink_f0", 32'hFFFF_FF03, 1'b0);
    checkFrame("blink_f1", 32'hFFFF_FF9F, 1'b0);
    checkFrame("blink_f2", BLINK_HIDDEN, 1'b0);
    checkFrame("blink_f3", BLINK_HIDDEN, 1'b0);
    checkFrame("blink_f4", 32'hFFFF_FF9F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
